// File: rtl/blackjack_pkg.sv
// blackjack_pkg: shared state encoding, result/destination codes and card valuation for the deal controller
package blackjack_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_ACCEPT, S_PLAYER_TURN, S_DEALER_CHK, S_RESOLVE, S_DONE
  } state_t;
  localparam logic [1:0] RES_PUSH   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic DEST_PLAYER = 1'b0;
  localparam logic DEST_DEALER = 1'b1;
  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_KING = 4'd13;
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd2 && rank <= 4'd10) ? rank : (rank == RANK_ACE) ? 4'd1 : 4'd10;
  endfunction
  function automatic logic rank_ok(input logic [3:0] rank);
    return rank != 4'd0 && rank <= RANK_KING;
  endfunction
endpackage

// File: rtl/blackjack_hand_acc.sv
// blackjack_hand_acc: one hand's hard total and ace flag, with the soft-ace best total
module blackjack_hand_acc (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear,
  input  logic       add,
  input  logic [3:0] value,
  input  logic       is_ace,
  output logic [5:0] hard,
  output logic       ace,
  output logic [5:0] best
);
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hard <= '0;
      ace  <= 1'b0;
    end else if (clear) begin
      hard <= '0;
      ace  <= 1'b0;
    end else if (add) begin
      hard <= hard + {2'b00, value};
      ace  <= ace | is_ace;
    end
  end
  assign best = (ace && hard <= 6'd11) ? hard + 6'd10 : hard;
endmodule

// File: rtl/blackjack_deal_ctrl.sv
// blackjack_deal_ctrl: round sequencer dealing P,D,P,D then player hits and dealer draws, resolving the winner.
// Define DEAL_CARD_CHECK_EN to discard and redraw cards with rank 0 or 14..15.
module blackjack_deal_ctrl
  import blackjack_pkg::*;
#(
  parameter int CARD_LAT     = 2,
  parameter int CARD_W       = 8,
  parameter int DEALER_STAND = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              player_hit_i,
  input  logic              player_stand_i,
  input  logic [CARD_W-1:0] card_i,
  output logic              request_card_o,
  output logic              card_valid_o,
  output logic [CARD_W-1:0] card_o,
  output logic              card_dest_o,
  output logic [5:0]        player_sum_o,
  output logic [5:0]        dealer_sum_o,
  output logic              busy_o,
  output logic              round_done_o,
  output logic [1:0]        result_o
);
  localparam int LW = $clog2(CARD_LAT + 1);
  state_t state, state_n;
  logic [LW-1:0] wcnt;
  logic [2:0] deal_cnt;
  logic dest, last, keep, take, clear;
  logic [3:0] rank;
  logic [5:0] p_hard, p_best, d_hard, d_best;
  logic p_ace, d_ace;
  logic unused_ok;
  assign rank  = card_i[3:0];
  assign last  = state == S_WAIT && wcnt == LW'(CARD_LAT);
`ifdef DEAL_CARD_CHECK_EN
  assign keep  = rank_ok(rank);
`else
  assign keep  = 1'b1;
`endif
  assign take  = last && keep;
  assign clear = state == S_IDLE && start_i;
  assign unused_ok = ^{p_ace, d_ace, card_i[CARD_W-1:4]};
  blackjack_hand_acc u_player (
    .clk_i(clk_i), .rst_i(rst_i), .clear(clear), .add(take && dest == DEST_PLAYER),
    .value(card_value(rank)), .is_ace(rank == RANK_ACE),
    .hard(p_hard), .ace(p_ace), .best(p_best)
  );
  blackjack_hand_acc u_dealer (
    .clk_i(clk_i), .rst_i(rst_i), .clear(clear), .add(take && dest == DEST_DEALER),
    .value(card_value(rank)), .is_ace(rank == RANK_ACE),
    .hard(d_hard), .ace(d_ace), .best(d_best)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_n;
  end
  // The card is summed at the sample edge so ACCEPT decides on up-to-date totals.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:        state_n = start_i ? S_REQ : S_IDLE;
      S_REQ:         state_n = S_WAIT;
      S_WAIT:        state_n = !last ? S_WAIT : keep ? S_ACCEPT : S_REQ;
      S_ACCEPT:      state_n = deal_cnt < 3'd3 ? S_REQ :
                               deal_cnt == 3'd3 ? (p_best == 6'd21 ? S_RESOLVE : S_PLAYER_TURN) :
                               dest == DEST_DEALER ? S_DEALER_CHK :
                               p_hard > 6'd21 ? S_RESOLVE :
                               p_best == 6'd21 ? S_DEALER_CHK : S_PLAYER_TURN;
      S_PLAYER_TURN: state_n = player_stand_i ? S_DEALER_CHK : player_hit_i ? S_REQ : S_PLAYER_TURN;
      S_DEALER_CHK:  state_n = d_best < 6'(DEALER_STAND) ? S_REQ : S_RESOLVE;
      S_RESOLVE:     state_n = S_DONE;
      S_DONE:        state_n = S_IDLE;
      default:       state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      card_valid_o <= 1'b0;
      card_o       <= '0;
      card_dest_o  <= 1'b0;
      result_o     <= RES_PUSH;
      wcnt         <= '0;
      deal_cnt     <= '0;
      dest         <= DEST_PLAYER;
    end else begin
      card_valid_o <= take;
      if (take) begin
        card_o      <= card_i;
        card_dest_o <= dest;
      end
      if (clear) begin
        result_o <= RES_PUSH;
        deal_cnt <= '0;
        dest     <= DEST_PLAYER;
      end
      if (state == S_REQ) wcnt <= LW'(1);
      else if (state == S_WAIT) wcnt <= wcnt + 1'b1;
      if (state == S_ACCEPT && deal_cnt != 3'd4) begin
        deal_cnt <= deal_cnt + 3'd1;
        dest     <= ~dest;
      end
      if (state == S_PLAYER_TURN && player_hit_i && !player_stand_i) dest <= DEST_PLAYER;
      if (state == S_DEALER_CHK) dest <= DEST_DEALER;
      if (state == S_RESOLVE)
        result_o <= p_hard > 6'd21 ? RES_DEALER :
                    d_hard > 6'd21 ? RES_PLAYER :
                    p_best > d_best ? RES_PLAYER :
                    p_best < d_best ? RES_DEALER : RES_PUSH;
    end
  end
  assign request_card_o = state == S_REQ;
  assign busy_o         = state != S_IDLE;
  assign round_done_o   = state == S_DONE;
  assign player_sum_o   = p_best;
  assign dealer_sum_o   = d_best;
endmodule
